// File: rtl/axis_pkg.sv
// Shared definitions for the round-robin AXI-Stream merge.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default beat and source-index widths
//   state_t                         : arbitration state (ARB, LOCKED)
//   rr_search()                     : rotating priority search over a request vector
package axis_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 16;
   localparam int unsigned DEF_ADDR_WIDTH = 4;

   // Widest request vector rr_search() can scan; callers zero-extend into it.
   localparam int unsigned MAX_ADDR_WIDTH = 8;
   localparam int unsigned MAX_REQ        = 1 << MAX_ADDR_WIDTH;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // First set bit of req in the order ptr, ptr+1, ..., num-1, 0, ..., ptr-1.
   // Returns 0 when nothing is requested; callers qualify with |req.
   function automatic int unsigned rr_search(input logic [MAX_REQ-1:0] req,
                                             input int unsigned         ptr,
                                             input int unsigned         num);
      int unsigned idx;
      int unsigned result;
      logic        found;
      result = 0;
      found  = 1'b0;
      for (int unsigned i = 0; i < num; i++) begin
         idx = ptr + i;
         if (idx >= num) idx = idx - num;
         if (!found && req[idx[MAX_ADDR_WIDTH-1:0]]) begin
            result = idx;
            found  = 1'b1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
//   req       : request vector, one bit per source
//   ptr       : index of the highest-priority source this cycle
//   enable    : when low, no grant is issued
//   grant_oh  : one-hot grant (zero when disabled or no request)
//   grant_idx : binary index of the winning source (valid when any_req)
//   any_req   : at least one request bit set
module rr_arbiter
   import axis_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   localparam int unsigned ADDR_NUM  = 1 << ADDR_WIDTH
) (
   input  logic [ADDR_NUM-1:0]   req,
   input  logic [ADDR_WIDTH-1:0] ptr,
   input  logic                  enable,
   output logic [ADDR_NUM-1:0]   grant_oh,
   output logic [ADDR_WIDTH-1:0] grant_idx,
   output logic                  any_req
);

   logic [MAX_REQ-1:0] req_ext;

   always_comb begin
      req_ext                = '0;
      req_ext[ADDR_NUM-1:0]  = req;
      grant_idx              = ADDR_WIDTH'(rr_search(req_ext, 32'(ptr), ADDR_NUM));
      any_req                = |req;
      grant_oh               = '0;
      if (enable && any_req) grant_oh[grant_idx] = 1'b1;
   end

endmodule

// File: rtl/axi_stream_mux_rr.sv
// Round-robin N-to-1 AXI-Stream merge with a single registered output slot.
// Each output beat carries the index of its source on taddr_o. With
// LOCK_ON_LAST=1 the grant is held on one source until its tlast.
//   aclk_i, aresetn_i : clock, asynchronous active-low reset
//   tdata_i/tlast_i/tvalid_i/tready_o : per-source input streams
//   tdata_o/taddr_o/tlast_o/tvalid_o/tready_i : merged output stream
module axi_stream_mux_rr
   import axis_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int unsigned LOCK_ON_LAST = 1,
   localparam int unsigned ADDR_NUM    = 1 << ADDR_WIDTH
) (
   input  logic                  aclk_i,
   input  logic                  aresetn_i,
   input  logic [DATA_WIDTH-1:0] tdata_i [0:ADDR_NUM-1],
   input  logic [ADDR_NUM-1:0]   tlast_i,
   input  logic [ADDR_NUM-1:0]   tvalid_i,
   output logic [ADDR_NUM-1:0]   tready_o,
   output logic [DATA_WIDTH-1:0] tdata_o,
   output logic [ADDR_WIDTH-1:0] taddr_o,
   output logic                  tlast_o,
   output logic                  tvalid_o,
   input  logic                  tready_i
);

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] ptr, ptr_next;
   logic [ADDR_WIDTH-1:0] lock_idx, lock_next;
   logic [ADDR_WIDTH-1:0] sel;
   logic [ADDR_NUM-1:0]   ready;
   logic                  accept;
   logic                  slot_free;

   logic [ADDR_NUM-1:0]   arb_oh;
   logic [ADDR_WIDTH-1:0] arb_idx;
   logic                  arb_any;

   // Slot can take a new beat when empty or being drained this cycle.
   assign slot_free = !tvalid_o || tready_i;

   rr_arbiter #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_arb (
      .req       (tvalid_i),
      .ptr       (ptr),
      .enable    (slot_free && (state == ARB)),
      .grant_oh  (arb_oh),
      .grant_idx (arb_idx),
      .any_req   (arb_any)
   );

   always_comb begin
      ready      = '0;
      accept     = 1'b0;
      sel        = arb_idx;
      state_next = state;
      ptr_next   = ptr;
      lock_next  = lock_idx;
      case (state)
         ARB: begin
            if (arb_any && slot_free) begin
               ready    = arb_oh;
               accept   = 1'b1;
               ptr_next = arb_idx + ADDR_WIDTH'(1);
               if ((LOCK_ON_LAST != 0) && !tlast_i[arb_idx]) begin
                  state_next = LOCKED;
                  lock_next  = arb_idx;
               end
            end
         end
         LOCKED: begin
            sel             = lock_idx;
            ready[lock_idx] = slot_free;
            if (slot_free && tvalid_i[lock_idx]) begin
               accept = 1'b1;
               if (tlast_i[lock_idx]) state_next = ARB;
            end
         end
         default: begin
            state_next = ARB;
         end
      endcase
      // tready_o must read zero for the whole time reset is held.
      if (!aresetn_i) begin
         ready  = '0;
         accept = 1'b0;
      end
   end

   assign tready_o = ready;

   always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         state    <= ARB;
         ptr      <= '0;
         lock_idx <= '0;
         tvalid_o <= 1'b0;
         tdata_o  <= '0;
         taddr_o  <= '0;
         tlast_o  <= 1'b0;
      end else begin
         state    <= state_next;
         ptr      <= ptr_next;
         lock_idx <= lock_next;
         if (accept) begin
            tvalid_o <= 1'b1;
            tdata_o  <= tdata_i[sel];
            taddr_o  <= sel;
            tlast_o  <= tlast_i[sel];
         end else if (tready_i) begin
            tvalid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_stream_mux_rr.sv
module tb_axi_stream_mux_rr;

   typedef struct packed {
      logic        last;
      logic [15:0] data;
   } beat_t;

   typedef struct packed {
      logic        last;
      logic [1:0]  addr;
      logic [15:0] data;
   } exp_t;

   logic        aclk;
   logic        aresetn;
   logic [15:0] tdata [0:3];
   logic [3:0]  tlast;
   logic [3:0]  tvalid;
   logic        tready_i;

   logic [3:0]  tready_o;
   logic [15:0] tdata_o;
   logic [1:0]  taddr_o;
   logic        tlast_o;
   logic        tvalid_o;

   logic [3:0]  b_tready_o;
   logic [15:0] b_tdata_o;
   logic [1:0]  b_taddr_o;
   logic        b_tlast_o;
   logic        b_tvalid_o;

   beat_t src_q [4][$];
   exp_t  exp_q[$];
   exp_t  exp_b_q[$];

   int    tests;
   int    failed;
   logic  static_mode;
   logic  b_mon_en;

   axi_stream_mux_rr #(
      .DATA_WIDTH   (16),
      .ADDR_WIDTH   (2),
      .LOCK_ON_LAST (1)
   ) u_dut (
      .aclk_i    (aclk),
      .aresetn_i (aresetn),
      .tdata_i   (tdata),
      .tlast_i   (tlast),
      .tvalid_i  (tvalid),
      .tready_o  (tready_o),
      .tdata_o   (tdata_o),
      .taddr_o   (taddr_o),
      .tlast_o   (tlast_o),
      .tvalid_o  (tvalid_o),
      .tready_i  (tready_i)
   );

   axi_stream_mux_rr #(
      .DATA_WIDTH   (16),
      .ADDR_WIDTH   (2),
      .LOCK_ON_LAST (0)
   ) u_dut_beat (
      .aclk_i    (aclk),
      .aresetn_i (aresetn),
      .tdata_i   (tdata),
      .tlast_i   (tlast),
      .tvalid_i  (tvalid),
      .tready_o  (b_tready_o),
      .tdata_o   (b_tdata_o),
      .taddr_o   (b_taddr_o),
      .tlast_o   (b_tlast_o),
      .tvalid_o  (b_tvalid_o),
      .tready_i  (tready_i)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #2;
   endtask

   task automatic push_src(input int s, input logic [15:0] data, input logic last);
      beat_t b;
      b.data = data;
      b.last = last;
      src_q[s].push_back(b);
   endtask

   task automatic push_exp(input logic [1:0] addr, input logic [15:0] data, input logic last);
      exp_t e;
      e.addr = addr;
      e.data = data;
      e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic push_exp_b(input logic [1:0] addr, input logic [15:0] data, input logic last);
      exp_t e;
      e.addr = addr;
      e.data = data;
      e.last = last;
      exp_b_q.push_back(e);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp_b_q.size() != 0) && n < 50) begin
         tick();
         n++;
      end
      check(tag, 32'(exp_q.size() + exp_b_q.size()), 32'd0);
   endtask

   // Source models: present the head of each queue, pop on a handshake
   // observed at the preceding falling edge.
   initial begin
      logic [3:0] hs;
      forever begin
         @(negedge aclk);
         hs = tvalid & tready_o;
         @(posedge aclk);
         #1;
         if (!static_mode) begin
            for (int s = 0; s < 4; s++) begin
               if (hs[s] && src_q[s].size() != 0) void'(src_q[s].pop_front());
               if (src_q[s].size() != 0) begin
                  tvalid[s] = 1'b1;
                  tdata[s]  = src_q[s][0].data;
                  tlast[s]  = src_q[s][0].last;
               end else begin
                  tvalid[s] = 1'b0;
                  tdata[s]  = '0;
                  tlast[s]  = 1'b0;
               end
            end
         end
      end
   end

   // Output monitor / scoreboard.
   always @(negedge aclk) begin
      exp_t e;
      check("tready_onehot", 32'($onehot0(tready_o)), 32'd1);
      if (aresetn && tvalid_o && tready_i) begin
         if (exp_q.size() == 0) begin
            check("extra_beat", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", 32'(tdata_o), 32'(e.data));
            check("beat_addr", 32'(taddr_o), 32'(e.addr));
            check("beat_last", 32'(tlast_o), 32'(e.last));
         end
      end
      if (b_mon_en && aresetn && b_tvalid_o && tready_i) begin
         if (exp_b_q.size() == 0) begin
            check("b_extra_beat", 32'(exp_b_q.size()), 32'd1);
         end else begin
            e = exp_b_q.pop_front();
            check("b_beat_data", 32'(b_tdata_o), 32'(e.data));
            check("b_beat_addr", 32'(b_taddr_o), 32'(e.addr));
            check("b_beat_last", 32'(b_tlast_o), 32'(e.last));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tests       = 0;
      failed      = 0;
      static_mode = 1'b1;
      b_mon_en    = 1'b0;
      aresetn     = 1'b0;
      tready_i    = 1'b0;
      tvalid      = 4'hF;
      tlast       = 4'h0;
      for (int s = 0; s < 4; s++) tdata[s] = 16'hFFFF;

      // Reset held with requests present.
      repeat (2) tick();
      check("rst_tready", 32'(tready_o), 32'd0);
      check("rst_b_tready", 32'(b_tready_o), 32'd0);
      check("rst_tvalid", 32'(tvalid_o), 32'd0);
      tvalid  = 4'h0;
      aresetn = 1'b1;

      // 1: idle after reset.
      for (int c = 0; c < 5; c++) begin
         tick();
         check("idle_tvalid", 32'(tvalid_o), 32'd0);
         check("idle_tready", 32'(tready_o), 32'd0);
      end
      check("idle_tdata", 32'(tdata_o), 32'd0);
      check("idle_taddr", 32'(taddr_o), 32'd0);
      check("idle_tlast", 32'(tlast_o), 32'd0);

      // 2: all sources valid, tlast low. Per-beat instance rotates;
      // locking instance stays on source 0 because no tlast arrives.
      b_mon_en = 1'b1;
      tready_i = 1'b1;
      for (int s = 0; s < 4; s++) tdata[s] = 16'hA0 + 16'(s);
      tvalid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         push_exp_b(2'(k % 4), 16'hA0 + 16'(k % 4), 1'b0);
         push_exp(2'd0, 16'hA0, 1'b0);
      end
      check("rr_first_latency", 32'(b_tvalid_o), 32'd0);
      repeat (5) tick();
      tvalid = 4'h0;
      tick();
      drain("drain_rr");
      b_mon_en = 1'b0;

      aresetn = 1'b0;
      tick();
      aresetn     = 1'b1;
      static_mode = 1'b0;
      tick();

      // 3: backpressure hold, then consume and refill in the same cycle.
      tready_i = 1'b0;
      push_src(2, 16'h1234, 1'b1);
      push_src(2, 16'h5678, 1'b1);
      push_exp(2'd2, 16'h1234, 1'b1);
      push_exp(2'd2, 16'h5678, 1'b1);
      repeat (2) tick();
      for (int c = 0; c < 3; c++) begin
         check("hold_tvalid", 32'(tvalid_o), 32'd1);
         check("hold_tdata", 32'(tdata_o), 32'h1234);
         check("hold_taddr", 32'(taddr_o), 32'd2);
         check("hold_tready", 32'(tready_o), 32'd0);
         tick();
      end
      tready_i = 1'b1;
      drain("drain_bp");

      // 4: packet lock. A beat from source 0 first moves ptr to 1.
      push_src(0, 16'h00AA, 1'b1);
      push_exp(2'd0, 16'h00AA, 1'b1);
      drain("drain_pre_lock");
      push_src(1, 16'h11, 1'b0);
      push_src(1, 16'h12, 1'b0);
      push_src(1, 16'h13, 1'b1);
      push_src(3, 16'h33, 1'b1);
      push_exp(2'd1, 16'h11, 1'b0);
      push_exp(2'd1, 16'h12, 1'b0);
      push_exp(2'd1, 16'h13, 1'b1);
      push_exp(2'd3, 16'h33, 1'b1);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("lock_tready", 32'(tready_o), 32'b0010);
      end
      drain("drain_lock");

      // 5: ptr wrapped to 0 after the source 3 grant; two full rounds.
      for (int r = 0; r < 2; r++) begin
         for (int s = 0; s < 4; s++) begin
            push_src(s, 16'h50 + 16'(r * 16 + s), 1'b1);
            push_exp(2'(s), 16'h50 + 16'(r * 16 + s), 1'b1);
         end
      end
      drain("drain_wrap");

      // 6: reset while locked on source 0 (which also moves ptr to 1).
      tready_i = 1'b0;
      push_src(0, 16'h70, 1'b0);
      push_src(0, 16'h71, 1'b0);
      push_src(0, 16'h72, 1'b1);
      repeat (2) tick();
      check("prerst_tvalid", 32'(tvalid_o), 32'd1);
      check("prerst_tdata", 32'(tdata_o), 32'h70);
      #1;
      aresetn = 1'b0;
      #1;
      check("async_rst_tvalid", 32'(tvalid_o), 32'd0);
      check("async_rst_tdata", 32'(tdata_o), 32'd0);
      check("async_rst_tready", 32'(tready_o), 32'd0);
      for (int s = 0; s < 4; s++) src_q[s].delete();
      repeat (2) tick();
      aresetn  = 1'b1;
      tready_i = 1'b1;
      push_src(2, 16'h82, 1'b1);
      push_src(0, 16'h80, 1'b1);
      push_exp(2'd0, 16'h80, 1'b1);
      push_exp(2'd2, 16'h82, 1'b1);
      drain("drain_post_rst");

      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
